// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths and FSM encodings for the pipeline controller
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DIV_CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        PC_ST_IDLE     = 2'd0,
        PC_ST_DIV_BUSY = 2'd1,
        PC_ST_DIV_DONE = 2'd2
    } pc_state_e;

endpackage

// File: rtl/dff_lr.sv
// rtl/dff_lr.sv - flop with load enable and synchronous active-low reset
module dff_lr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID-stage read of a register still being loaded in EX
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_re_i,
    input  logic                  id_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_rd_we_i,
    input  logic                  ex_is_load_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_re_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_rs2_re_i & (id_rs2_addr_i == ex_rd_addr_i);

    // x0 is never a real dependency, so a load targeting it cannot create a hazard
    assign load_use_o = id_valid_i & ex_is_load_i & ex_rd_we_i
                      & (ex_rd_addr_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard, redirect and divider-freeze controller for the 5-stage core
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_re_i,
    input  logic                  id_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_rd_we_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_div_i,
    input  logic                  ex_jump_i,
    input  logic [31:0]           ex_jump_addr_i,
    output logic                  stall_pc_o,
    output logic                  stall_if_id_o,
    output logic                  stall_id_ex_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  flush_ex_mem_o,
    output logic                  jump_o,
    output logic [31:0]           jump_addr_o,
    output logic                  div_start_o,
    output logic                  div_res_sel_o,
    output logic [31:0]           stall_cnt_o
);

    localparam logic [DIV_CNT_WIDTH-1:0] DIV_LOAD = DIV_CNT_WIDTH'(DIV_CYCLES - 1);

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    pc_state_e                state;
    logic [DIV_CNT_WIDTH-1:0] div_cnt_q;
    logic [DIV_CNT_WIDTH-1:0] div_cnt_d;
    logic [31:0]              stall_cnt_q;
    logic                     load_use;

    logic stall_pc, stall_if_id, stall_id_ex;
    logic flush_if_id, flush_id_ex, flush_ex_mem;
    logic jump, div_start, div_res_sel;

    load_use_detect u_load_use_detect (
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_re_i   (id_rs1_re_i),
        .id_rs2_re_i   (id_rs2_re_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_rd_we_i    (ex_rd_we_i),
        .ex_is_load_i  (ex_is_load_i),
        .load_use_o    (load_use)
    );

    assign state = pc_state_e'(state_q);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        jump         = 1'b0;
        div_start    = 1'b0;
        div_res_sel  = 1'b0;
        case (state)
            PC_ST_IDLE: begin
                if (ex_jump_i) begin
                    jump        = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (ex_div_i) begin
                    div_start    = 1'b1;
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    div_cnt_d    = DIV_LOAD;
                    state_d      = PC_ST_DIV_BUSY;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            PC_ST_DIV_BUSY: begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                if (div_cnt_q == '0) begin
                    state_d = PC_ST_DIV_DONE;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            PC_ST_DIV_DONE: begin
                // ex_div_i is still high for the finishing instruction; it must not restart
                div_res_sel = 1'b1;
                state_d     = PC_ST_IDLE;
            end
            default: begin
                state_d = PC_ST_IDLE;
            end
        endcase
    end

    dff_lr #(.WIDTH(2), .RST_VAL(PC_ST_IDLE)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b1),
        .d     (state_d),
        .q     (state_q)
    );

    dff_lr #(.WIDTH(DIV_CNT_WIDTH)) u_div_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (1'b1),
        .d     (div_cnt_d),
        .q     (div_cnt_q)
    );

    dff_lr #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (stall_pc),
        .d     (stall_cnt_q + 32'd1),
        .q     (stall_cnt_q)
    );

    // Everything is held quiet while reset is asserted, even before the first reset edge
    assign stall_pc_o     = rst_n & stall_pc;
    assign stall_if_id_o  = rst_n & stall_if_id;
    assign stall_id_ex_o  = rst_n & stall_id_ex;
    assign flush_if_id_o  = rst_n & flush_if_id;
    assign flush_id_ex_o  = rst_n & flush_id_ex;
    assign flush_ex_mem_o = rst_n & flush_ex_mem;
    assign jump_o         = rst_n & jump;
    assign jump_addr_o    = (rst_n & jump) ? ex_jump_addr_i : 32'd0;
    assign div_start_o    = rst_n & div_start;
    assign div_res_sel_o  = rst_n & div_res_sel;
    assign stall_cnt_o    = rst_n ? stall_cnt_q : 32'd0;

endmodule
